r2r_pulse_sequencer: RTL and testbench



---
 rtl/r2r_pulse_sequencer_if.sv | 28 ++
 rtl/r2r_pulse_sequencer.sv | 147 ++++++++++++++
 tb/tb_r2r_pulse_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/r2r_pulse_sequencer_if.sv
// r2r_pulse_sequencer_if: config, control, status and DAC drive bundle between the register bank and the sequencer.
interface r2r_pulse_sequencer_if #(
    parameter int DAC_BITS = 8,
    parameter int CNT_W    = 16
);
    logic [DAC_BITS-1:0] cfg_base_code;
    logic [DAC_BITS-1:0] cfg_pulse_code;
    logic [CNT_W-1:0]    cfg_pulse_width;
    logic [CNT_W-1:0]    cfg_gap_width;
    logic [CNT_W-1:0]    cfg_pulse_count;
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [DAC_BITS-1:0] dac_code;
    logic                dac_update;
    logic                pulse_active;
    logic [CNT_W-1:0]    pulses_done;
    modport master (
        output cfg_base_code, cfg_pulse_code, cfg_pulse_width, cfg_gap_width, cfg_pulse_count, start, abort,
        input  busy, done, aborted, dac_code, dac_update, pulse_active, pulses_done
    );
    modport slave (
        input  cfg_base_code, cfg_pulse_code, cfg_pulse_width, cfg_gap_width, cfg_pulse_count, start, abort,
        output busy, done, aborted, dac_code, dac_update, pulse_active, pulses_done
    );
endinterface

// File: rtl/r2r_pulse_sequencer.sv
// r2r_pulse_sequencer: alternates the R-2R code between base and pulse levels for a programmed train.
// Define R2R_BLANK_EN to insert a one-cycle all-zero blank cycle on every base/pulse level change.
module r2r_pulse_sequencer #(
    parameter int DAC_BITS = 8,
    parameter int CNT_W    = 16
) (
    input logic             ACLK,
    input logic             ARESETN,
    r2r_pulse_sequencer_if.slave io
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, BLANK} state_t;
    state_t              state, state_nx;
    logic [DAC_BITS-1:0] base_q, pulse_q, code_q, code_nx;
    logic [CNT_W-1:0]    width_q, gap_q, count_q, cnt, cnt_nx, pdone, pdone_nx, pd_inc, gap_ld;
    logic                done_q, done_nx, upd_q, upd_nx, abrt_q, abrt_nx, latch, last;
`ifdef R2R_BLANK_EN
    state_t              tgt, tgt_nx;
`endif
    assign pd_inc = pdone + CNT_W'(1);
    assign last   = pd_inc == count_q;
    assign gap_ld = gap_q == '0 ? '0 : gap_q - CNT_W'(1);
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pdone_nx = pdone;
        code_nx  = code_q;
        done_nx  = 1'b0;
        upd_nx   = 1'b0;
        abrt_nx  = abrt_q;
        latch    = 1'b0;
`ifdef R2R_BLANK_EN
        tgt_nx   = tgt;
`endif
        if (state == IDLE) begin
            if (io.start) begin
                latch    = 1'b1;
                pdone_nx = '0;
                abrt_nx  = 1'b0;
                upd_nx   = 1'b1;
                if (io.cfg_pulse_count == '0 || io.cfg_pulse_width == '0) begin
                    code_nx = io.cfg_base_code;
                    done_nx = 1'b1;
                end else begin
                    cnt_nx = io.cfg_pulse_width - CNT_W'(1);
`ifdef R2R_BLANK_EN
                    state_nx = BLANK;
                    tgt_nx   = PULSE;
                    code_nx  = '0;
`else
                    state_nx = PULSE;
                    code_nx  = io.cfg_pulse_code;
`endif
                end
            end
        end else if (io.abort) begin
            // a pulse finishing in the abort cycle still counts
            state_nx = IDLE;
            code_nx  = base_q;
            upd_nx   = 1'b1;
            done_nx  = 1'b1;
            abrt_nx  = 1'b1;
            pdone_nx = state == PULSE && cnt == '0 ? pd_inc : pdone;
        end else if (state == PULSE) begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == '0) begin
                pdone_nx = pd_inc;
                upd_nx   = 1'b1;
                cnt_nx   = gap_ld;
`ifdef R2R_BLANK_EN
                state_nx = BLANK;
                tgt_nx   = last ? IDLE : GAP;
                code_nx  = '0;
`else
                state_nx = last ? IDLE : GAP;
                code_nx  = base_q;
                done_nx  = last;
`endif
            end
        end else if (state == GAP) begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == '0) begin
                upd_nx = 1'b1;
                cnt_nx = width_q - CNT_W'(1);
`ifdef R2R_BLANK_EN
                state_nx = BLANK;
                tgt_nx   = PULSE;
                code_nx  = '0;
`else
                state_nx = PULSE;
                code_nx  = pulse_q;
`endif
            end
        end
`ifdef R2R_BLANK_EN
        else begin
            state_nx = tgt;
            upd_nx   = 1'b1;
            code_nx  = tgt == PULSE ? pulse_q : base_q;
            done_nx  = tgt == IDLE;
        end
`endif
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            cnt     <= '0;
            pdone   <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            abrt_q  <= 1'b0;
            base_q  <= '0;
            pulse_q <= '0;
            width_q <= '0;
            gap_q   <= '0;
            count_q <= '0;
`ifdef R2R_BLANK_EN
            tgt     <= IDLE;
`endif
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pdone  <= pdone_nx;
            code_q <= code_nx;
            done_q <= done_nx;
            upd_q  <= upd_nx;
            abrt_q <= abrt_nx;
`ifdef R2R_BLANK_EN
            tgt    <= tgt_nx;
`endif
            if (latch) begin
                base_q  <= io.cfg_base_code;
                pulse_q <= io.cfg_pulse_code;
                width_q <= io.cfg_pulse_width;
                gap_q   <= io.cfg_gap_width;
                count_q <= io.cfg_pulse_count;
            end
        end
    end
    assign io.busy         = state != IDLE;
    assign io.pulse_active = state == PULSE;
    assign io.done         = done_q;
    assign io.aborted      = abrt_q;
    assign io.dac_code     = code_q;
    assign io.dac_update   = upd_q;
    assign io.pulses_done  = pdone;
endmodule

// File: tb/tb_r2r_pulse_sequencer.sv
// tb_r2r_pulse_sequencer: directed checks of train timing, zero/boundary configs, abort, shadowing and async reset.
module tb_r2r_pulse_sequencer;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    int   nvec = 0;
    int   nmis = 0;
    int   c;
    r2r_pulse_sequencer_if #(.DAC_BITS(8), .CNT_W(16)) io ();
    r2r_pulse_sequencer #(.DAC_BITS(8), .CNT_W(16)) dut (.ACLK(ACLK), .ARESETN(ARESETN), .io(io.slave));
    always #5 ACLK = ~ACLK;
`ifdef R2R_BLANK_EN
    localparam int B = 1;
    localparam int N = 14;
    logic [7:0]  ec [N] = '{8'h00, 8'hC0, 8'hC0, 8'hC0, 8'h00, 8'h10, 8'h10, 8'h00, 8'hC0, 8'hC0, 8'hC0, 8'h00, 8'h10, 8'h10};
    logic        eb [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic        ed [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        eu [N] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [15:0] ep [N] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2};
`else
    localparam int B = 0;
    localparam int N = 10;
    logic [7:0]  ec [N] = '{8'hC0, 8'hC0, 8'hC0, 8'h10, 8'h10, 8'hC0, 8'hC0, 8'hC0, 8'h10, 8'h10};
    logic        eb [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic        ed [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic        eu [N] = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 0};
    logic [15:0] ep [N] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2};
`endif
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cfg(input logic [7:0] b, input logic [7:0] p, input logic [15:0] w, input logic [15:0] g, input logic [15:0] n);
        io.cfg_base_code   = b;
        io.cfg_pulse_code  = p;
        io.cfg_pulse_width = w;
        io.cfg_gap_width   = g;
        io.cfg_pulse_count = n;
    endtask
    task automatic go();
        io.start = 1'b1;
        tick();
        io.start = 1'b0;
    endtask
    task automatic run_to_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!io.done && n < 1000);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        io.start = 1'b0;
        io.abort = 1'b0;
        cfg(8'h10, 8'hC0, 16'd3, 16'd2, 16'd2);
        tick();
        tick();
        chk("rst_code", io.dac_code, 8'h00);
        chk("rst_busy", io.busy, 1'b0);
        chk("rst_done", io.done, 1'b0);
        chk("rst_aborted", io.aborted, 1'b0);
        chk("rst_upd", io.dac_update, 1'b0);
        chk("rst_pact", io.pulse_active, 1'b0);
        chk("rst_pdone", io.pulses_done, 16'd0);
        ARESETN = 1'b1;
        tick();
        go();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("basic_code[T+%0d]", i + 1), io.dac_code, ec[i]);
            chk($sformatf("basic_busy[T+%0d]", i + 1), io.busy, eb[i]);
            chk($sformatf("basic_done[T+%0d]", i + 1), io.done, ed[i]);
            chk($sformatf("basic_upd[T+%0d]", i + 1), io.dac_update, eu[i]);
            chk($sformatf("basic_pact[T+%0d]", i + 1), io.pulse_active, ec[i] == 8'hC0);
            chk($sformatf("basic_pdone[T+%0d]", i + 1), io.pulses_done, ep[i]);
            tick();
        end
        cfg(8'h22, 8'hC0, 16'd3, 16'd2, 16'd0);
        go();
        chk("zcount_done", io.done, 1'b1);
        chk("zcount_busy", io.busy, 1'b0);
        chk("zcount_code", io.dac_code, 8'h22);
        chk("zcount_upd", io.dac_update, 1'b1);
        chk("zcount_pdone", io.pulses_done, 16'd0);
        tick();
        chk("zcount_done_clr", io.done, 1'b0);
        cfg(8'h10, 8'hC0, 16'd0, 16'd2, 16'd1);
        go();
        chk("zwidth_done", io.done, 1'b1);
        chk("zwidth_busy", io.busy, 1'b0);
        chk("zwidth_code", io.dac_code, 8'h10);
        cfg(8'h10, 8'hC0, 16'd1, 16'd0, 16'd2);
        go();
        run_to_done(c);
        chk("zgap_len", c, 3 + 4 * B);
        chk("zgap_pdone", io.pulses_done, 16'd2);
        cfg(8'h10, 8'hC0, 16'd100, 16'd2, 16'd5);
        go();
        for (int i = 0; i < 400 && !(io.pulses_done == 16'd1 && io.pulse_active); i++) tick();
        chk("abort_reach_p2", io.pulse_active, 1'b1);
        repeat (5) tick();
        io.abort = 1'b1;
        tick();
        io.abort = 1'b0;
        chk("abort_code", io.dac_code, 8'h10);
        chk("abort_busy", io.busy, 1'b0);
        chk("abort_done", io.done, 1'b1);
        chk("abort_flag", io.aborted, 1'b1);
        chk("abort_pdone", io.pulses_done, 16'd1);
        chk("abort_pact", io.pulse_active, 1'b0);
        tick();
        chk("abort_sticky", io.aborted, 1'b1);
        chk("abort_done_clr", io.done, 1'b0);
        cfg(8'h10, 8'hC0, 16'd3, 16'd2, 16'd2);
        go();
        chk("restart_aborted_clr", io.aborted, 1'b0);
        chk("restart_busy", io.busy, 1'b1);
        io.cfg_pulse_code = 8'h55;
        go();
        chk("shadow_code", io.dac_code, 8'hC0);
        run_to_done(c);
        chk("shadow_len", c, 7 + 4 * B);
        chk("shadow_pdone", io.pulses_done, 16'd2);
        tick();
        io.abort = 1'b1;
        tick();
        io.abort = 1'b0;
        chk("idle_abort_flag", io.aborted, 1'b0);
        chk("idle_abort_done", io.done, 1'b0);
        chk("idle_abort_busy", io.busy, 1'b0);
        io.abort = 1'b1;
        go();
        io.abort = 1'b0;
        chk("start_abort_busy", io.busy, 1'b1);
        chk("start_abort_flag", io.aborted, 1'b0);
        repeat (B) tick();
        chk("new_cfg_code", io.dac_code, 8'h55);
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_code", io.dac_code, 8'h00);
        chk("arst_busy", io.busy, 1'b0);
        chk("arst_pact", io.pulse_active, 1'b0);
        chk("arst_pdone", io.pulses_done, 16'd0);
        tick();
        ARESETN = 1'b1;
        tick();
        chk("arst_idle", io.busy, 1'b0);
        cfg(8'h10, 8'hC0, 16'd2, 16'd1, 16'd3);
        go();
        repeat (1 + B) tick();
        chk("endabort_pact", io.pulse_active, 1'b1);
        io.abort = 1'b1;
        tick();
        io.abort = 1'b0;
        chk("endabort_pdone", io.pulses_done, 16'd1);
        chk("endabort_flag", io.aborted, 1'b1);
        chk("endabort_done", io.done, 1'b1);
        chk("endabort_busy", io.busy, 1'b0);
        chk("endabort_code", io.dac_code, 8'h10);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
